// File: rtl/bubble_pkg.sv
// bubble_pkg: shared types and helpers for the bubble pool.
// Holds the slot-state struct, FSM encoding, diameter and bounce-velocity functions.
package bubble_pkg;

   typedef struct packed {
      logic              active;
      logic              pending;
      logic [2:0]        size;
      logic [10:0]       x;
      logic [10:0]       y;
      logic              dir;
      logic signed [7:0] vy;
   } slot_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_UPDATE,
      S_SPLIT,
      S_DONE
   } state_t;

   // Both children of a split start with this upward kick.
   localparam logic signed [7:0] SPLIT_VY = -8'sd16;

   function automatic logic [11:0] diam(
      input logic [2:0] size,
      input int         base
   );
      return 12'(base << size);
   endfunction

   // Floor bounce velocity: bigger bubbles jump higher.
   function automatic logic signed [7:0] bounce_vy(
      input logic [2:0] size
   );
      return -(8'sd12 + $signed({3'b000, size, 2'b00}));
   endfunction

endpackage

// File: rtl/bubble_hit_test.sv
// bubble_hit_test: combinational priority bounding-box search over all slots.
// Ports: slots (slot array), px/py (pixel), hit/slot/size/off_x/off_y (lowest covering slot, zeros if none).
module bubble_hit_test
   import bubble_pkg::*;
#(
   parameter int NUM_SLOTS = 8,
   parameter int BASE_DIAM = 8
)(
   input  slot_t                          slots [NUM_SLOTS],
   input  logic [10:0]                    px,
   input  logic [10:0]                    py,
   output logic                           hit,
   output logic [$clog2(NUM_SLOTS)-1:0]   slot,
   output logic [2:0]                     size,
   output logic [10:0]                    off_x,
   output logic [10:0]                    off_y
);

   localparam int SW = $clog2(NUM_SLOTS);

   // Scan from the top so the lowest covering index is written last.
   always_comb begin
      hit   = 1'b0;
      slot  = '0;
      size  = '0;
      off_x = '0;
      off_y = '0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (slots[i].active &&
             px >= slots[i].x &&
             py >= slots[i].y &&
             {1'b0, px} < {1'b0, slots[i].x} +
                          diam(slots[i].size, BASE_DIAM) &&
             {1'b0, py} < {1'b0, slots[i].y} +
                          diam(slots[i].size, BASE_DIAM)) begin
            hit   = 1'b1;
            slot  = SW'(i);
            size  = slots[i].size;
            off_x = px - slots[i].x;
            off_y = py - slots[i].y;
         end
      end
   end

endmodule

// File: rtl/bubble_pool.sv
// bubble_pool: multi-slot bubble manager with per-frame physics, split/pop and pixel query.
// Ports: clk, reset (async high), startOfFrame, spawn_* handshake, hit_valid/hit_slot,
// pixelX/pixelY -> registered draw outputs, activeCount, split and allCleared pulses.
// Optional: define BUBBLE_POOL_FREEZE_EN to add input freeze (motion skipped while high).
module bubble_pool
   import bubble_pkg::*;
#(
   parameter int NUM_SLOTS = 8,
   parameter int MAX_SIZE  = 3,
   parameter int BASE_DIAM = 8,
   parameter int SCREEN_W  = 640,
   parameter int FLOOR_Y   = 440,
   parameter int X_SPEED   = 2,
   parameter int GRAVITY   = 1
)(
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          startOfFrame,
   input  logic                          spawn_valid,
   output logic                          spawn_ready,
   input  logic [2:0]                    spawn_size,
   input  logic [10:0]                   spawn_x,
   input  logic [10:0]                   spawn_y,
   input  logic                          spawn_dir,
   input  logic                          hit_valid,
   input  logic [$clog2(NUM_SLOTS)-1:0]  hit_slot,
`ifdef BUBBLE_POOL_FREEZE_EN
   input  logic                          freeze,
`endif
   input  logic [10:0]                   pixelX,
   input  logic [10:0]                   pixelY,
   output logic                          drawingRequest,
   output logic [$clog2(NUM_SLOTS)-1:0]  drawSlot,
   output logic [2:0]                    drawSize,
   output logic [10:0]                   offsetX,
   output logic [10:0]                   offsetY,
   output logic [$clog2(NUM_SLOTS):0]    activeCount,
   output logic                          split,
   output logic                          allCleared
);

   localparam int SW = $clog2(NUM_SLOTS);
   localparam logic [SW-1:0] LAST = SW'(NUM_SLOTS - 1);
   localparam logic signed [12:0] XS    = 13'(X_SPEED);
   localparam logic signed [12:0] WALL  = 13'(SCREEN_W);
   localparam logic signed [12:0] FLOOR = 13'(FLOOR_Y);
   localparam logic signed [8:0]  GR    = 9'(GRAVITY);

   slot_t             slots [NUM_SLOTS];
   slot_t             nxt   [NUM_SLOTS];
   logic [NUM_SLOTS-1:0] fresh, fresh_nxt;
   state_t            state, state_nxt;
   logic [SW-1:0]     idx, idx_nxt;
   logic [SW:0]       cnt, cnt_nxt;
   logic [SW-1:0]     free_idx;
   logic              free_any;
   logic              frozen, busy, hit_ok, advance;
   slot_t             cur, moved;
   logic signed [12:0] dm, nx, ny;
   logic signed [8:0] vs;
   logic signed [7:0] vn;
   logic              h_hit;
   logic [SW-1:0]     h_slot;
   logic [2:0]        h_size;
   logic [10:0]       h_ox, h_oy;

`ifdef BUBBLE_POOL_FREEZE_EN
   assign frozen = freeze;
`else
   assign frozen = 1'b0;
`endif

   always_comb begin
      free_any = 1'b0;
      free_idx = '0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (!slots[i].active) begin
            free_any = 1'b1;
            free_idx = SW'(i);
         end
      end
   end

   always_comb begin
      cnt = '0;
      for (int i = 0; i < NUM_SLOTS; i++)
         cnt = cnt + {{SW{1'b0}}, slots[i].active};
   end

   assign cur         = slots[idx];
   assign busy        = (state == S_UPDATE) || (state == S_SPLIT);
   assign spawn_ready = !reset && (state == S_IDLE) && free_any;
   assign hit_ok      = hit_valid &&
                        int'(hit_slot) < NUM_SLOTS &&
                        slots[hit_slot].active &&
                        !slots[hit_slot].pending &&
                        !(busy && hit_slot == idx);

   // One frame of motion for the slot under the cursor.
   always_comb begin
      moved = cur;
      dm = $signed({1'b0, diam(cur.size, BASE_DIAM)});
      nx = cur.dir ? $signed({2'b00, cur.x}) + XS
                   : $signed({2'b00, cur.x}) - XS;
      if (nx <= 13'sd0) begin
         moved.x   = '0;
         moved.dir = 1'b1;
      end else if (nx + dm >= WALL) begin
         moved.x   = 11'(WALL - dm);
         moved.dir = 1'b0;
      end else begin
         moved.x = nx[10:0];
      end
      vs = $signed({cur.vy[7], cur.vy}) + GR;
      if (vs > 9'sd127)
         vn = 8'sd127;
      else if (vs < -9'sd127)
         vn = -8'sd127;
      else
         vn = vs[7:0];
      moved.vy = vn;
      ny = $signed({2'b00, cur.y}) + $signed({{5{vn[7]}}, vn});
      if (ny + dm >= FLOOR) begin
         moved.y  = 11'(FLOOR - dm);
         moved.vy = bounce_vy(cur.size);
      end else if (ny < 13'sd0) begin
         // Keep the unsigned coordinate from wrapping above the screen.
         moved.y = '0;
      end else begin
         moved.y = ny[10:0];
      end
   end

   always_comb begin
      nxt        = slots;
      fresh_nxt  = fresh;
      state_nxt  = state;
      idx_nxt    = idx;
      cnt_nxt    = activeCount;
      split      = 1'b0;
      allCleared = 1'b0;
      advance    = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (startOfFrame) begin
               state_nxt = S_UPDATE;
               idx_nxt   = '0;
            end
         end
         S_UPDATE: begin
            advance = 1'b1;
            // Children created earlier in this pass are left alone.
            if (cur.active && !fresh[idx]) begin
               if (cur.pending && cur.size != 3'd0) begin
                  state_nxt = S_SPLIT;
                  advance   = 1'b0;
               end else if (cur.pending) begin
                  nxt[idx] = '0;
                  split    = 1'b1;
               end else if (!frozen) begin
                  nxt[idx] = moved;
               end
            end
         end
         S_SPLIT: begin
            advance = 1'b1;
            split   = 1'b1;
            nxt[idx].size    = cur.size - 3'd1;
            nxt[idx].dir     = 1'b0;
            nxt[idx].vy      = SPLIT_VY;
            nxt[idx].pending = 1'b0;
            if (free_any) begin
               nxt[free_idx] = '{active:  1'b1,
                                 pending: 1'b0,
                                 size:    cur.size - 3'd1,
                                 x:       cur.x,
                                 y:       cur.y,
                                 dir:     1'b1,
                                 vy:      SPLIT_VY};
               fresh_nxt[free_idx] = 1'b1;
            end
         end
         S_DONE: begin
            cnt_nxt    = cnt;
            allCleared = (cnt == '0) && (activeCount != '0);
            fresh_nxt  = '0;
            state_nxt  = S_IDLE;
         end
      endcase
      if (advance) begin
         if (idx == LAST) begin
            state_nxt = S_DONE;
         end else begin
            state_nxt = S_UPDATE;
            idx_nxt   = idx + 1'b1;
         end
      end
      if (spawn_valid && spawn_ready) begin
         nxt[free_idx] = '{active:  1'b1,
                           pending: 1'b0,
                           size:    (spawn_size > 3'(MAX_SIZE))
                                    ? 3'(MAX_SIZE) : spawn_size,
                           x:       spawn_x,
                           y:       spawn_y,
                           dir:     spawn_dir,
                           vy:      8'sd0};
      end
      if (hit_ok)
         nxt[hit_slot].pending = 1'b1;
   end

   bubble_hit_test #(
      .NUM_SLOTS (NUM_SLOTS),
      .BASE_DIAM (BASE_DIAM)
   ) u_hit (
      .slots (slots),
      .px    (pixelX),
      .py    (pixelY),
      .hit   (h_hit),
      .slot  (h_slot),
      .size  (h_size),
      .off_x (h_ox),
      .off_y (h_oy)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= S_IDLE;
         idx            <= '0;
         fresh          <= '0;
         activeCount    <= '0;
         drawingRequest <= 1'b0;
         drawSlot       <= '0;
         drawSize       <= '0;
         offsetX        <= '0;
         offsetY        <= '0;
         for (int i = 0; i < NUM_SLOTS; i++)
            slots[i] <= '0;
      end else begin
         state          <= state_nxt;
         idx            <= idx_nxt;
         fresh          <= fresh_nxt;
         activeCount    <= cnt_nxt;
         drawingRequest <= h_hit;
         drawSlot       <= h_slot;
         drawSize       <= h_size;
         offsetX        <= h_ox;
         offsetY        <= h_oy;
         slots          <= nxt;
      end
   end

endmodule

// File: tb/tb_bubble_pool.sv
// tb_bubble_pool: self-checking bench for bubble_pool against a behavioural slot model.
// Scenario tasks drive spawns, hits, frames and pixel queries, comparing state and outputs.
module tb_bubble_pool;
   import bubble_pkg::*;

   localparam int NS = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        sof;
   logic        spawn_valid, spawn_ready, spawn_dir;
   logic [2:0]  spawn_size;
   logic [10:0] spawn_x, spawn_y;
   logic        hit_valid;
   logic [2:0]  hit_slot;
   logic [10:0] pixelX, pixelY;
   logic        drawingRequest;
   logic [2:0]  drawSlot, drawSize;
   logic [10:0] offsetX, offsetY;
   logic [3:0]  activeCount;
   logic        split, allCleared;

   int checks = 0;
   int errors = 0;

   int m_act [NS];
   int m_pend[NS];
   int m_size[NS];
   int m_x   [NS];
   int m_y   [NS];
   int m_dir [NS];
   int m_vy  [NS];
   int m_cnt;

   always #5 clk = ~clk;

   bubble_pool dut (
      .clk            (clk),
      .reset          (reset),
      .startOfFrame   (sof),
      .spawn_valid    (spawn_valid),
      .spawn_ready    (spawn_ready),
      .spawn_size     (spawn_size),
      .spawn_x        (spawn_x),
      .spawn_y        (spawn_y),
      .spawn_dir      (spawn_dir),
      .hit_valid      (hit_valid),
      .hit_slot       (hit_slot),
`ifdef BUBBLE_POOL_FREEZE_EN
      .freeze         (1'b0),
`endif
      .pixelX         (pixelX),
      .pixelY         (pixelY),
      .drawingRequest (drawingRequest),
      .drawSlot       (drawSlot),
      .drawSize       (drawSize),
      .offsetX        (offsetX),
      .offsetY        (offsetY),
      .activeCount    (activeCount),
      .split          (split),
      .allCleared     (allCleared)
   );

   // ---------------- reference model ----------------
   task automatic model_clear();
      for (int i = 0; i < NS; i++) begin
         m_act[i] = 0; m_pend[i] = 0; m_size[i] = 0;
         m_x[i] = 0; m_y[i] = 0; m_dir[i] = 0; m_vy[i] = 0;
      end
      m_cnt = 0;
   endtask

   function automatic int lowest_free();
      for (int i = 0; i < NS; i++)
         if (m_act[i] == 0) return i;
      return -1;
   endfunction

   task automatic model_move(input int i);
      int d;
      d = 8 << m_size[i];
      m_x[i] = m_x[i] + (m_dir[i] != 0 ? 2 : -2);
      if (m_x[i] <= 0) begin
         m_x[i] = 0; m_dir[i] = 1;
      end else if (m_x[i] + d >= 640) begin
         m_x[i] = 640 - d; m_dir[i] = 0;
      end
      m_vy[i] = m_vy[i] + 1;
      if (m_vy[i] > 127) m_vy[i] = 127;
      if (m_vy[i] < -127) m_vy[i] = -127;
      m_y[i] = m_y[i] + m_vy[i];
      if (m_y[i] + d >= 440) begin
         m_y[i] = 440 - d;
         m_vy[i] = -(12 + 4 * m_size[i]);
      end else if (m_y[i] < 0) begin
         m_y[i] = 0;
      end
   endtask

   task automatic model_frame(output int splits, output int cleared);
      bit fresh[NS];
      int j, c;
      splits = 0;
      for (int i = 0; i < NS; i++) fresh[i] = 0;
      for (int i = 0; i < NS; i++) begin
         if (m_act[i] != 0 && !fresh[i]) begin
            if (m_pend[i] != 0 && m_size[i] > 0) begin
               splits++;
               m_size[i]--; m_dir[i] = 0; m_vy[i] = -16; m_pend[i] = 0;
               j = lowest_free();
               if (j >= 0) begin
                  m_act[j] = 1; m_pend[j] = 0; m_size[j] = m_size[i];
                  m_x[j] = m_x[i]; m_y[j] = m_y[i];
                  m_dir[j] = 1; m_vy[j] = -16; fresh[j] = 1;
               end
            end else if (m_pend[i] != 0) begin
               splits++;
               m_act[i] = 0; m_pend[i] = 0; m_size[i] = 0;
               m_x[i] = 0; m_y[i] = 0; m_dir[i] = 0; m_vy[i] = 0;
            end else begin
               model_move(i);
            end
         end
      end
      c = 0;
      for (int i = 0; i < NS; i++) c += m_act[i];
      cleared = (c == 0 && m_cnt != 0) ? 1 : 0;
      m_cnt = c;
   endtask

   // ---------------- drivers / checkers ----------------
   task automatic check_state(input string tag);
      logic [35:0] o, e;
      for (int i = 0; i < NS; i++) begin
         checks++;
         o = {dut.slots[i].active, dut.slots[i].pending,
              dut.slots[i].size, dut.slots[i].x, dut.slots[i].y,
              dut.slots[i].dir, dut.slots[i].vy};
         if (m_act[i] != 0) begin
            e = {1'b1, 1'(m_pend[i]), 3'(m_size[i]), 11'(m_x[i]),
                 11'(m_y[i]), 1'(m_dir[i]), 8'(m_vy[i])};
            if (o !== e) begin
               errors++;
               $display("FAIL %s slot%0d: got %h expected %h",
                        tag, i, o, e);
            end
         end else if (o[35] !== 1'b0) begin
            errors++;
            $display("FAIL %s slot%0d active: got 1 expected 0", tag, i);
         end
      end
   endtask

   task automatic do_reset();
      reset = 1'b1; sof = 1'b0; spawn_valid = 1'b0; hit_valid = 1'b0;
      spawn_size = '0; spawn_x = '0; spawn_y = '0; spawn_dir = 1'b0;
      hit_slot = '0; pixelX = '0; pixelY = '0;
      model_clear();
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic spawn(input int sz, input int x, input int y,
                        input int dir);
      int j;
      j = lowest_free();
      @(negedge clk);
      spawn_valid = 1'b1; spawn_size = 3'(sz);
      spawn_x = 11'(x); spawn_y = 11'(y); spawn_dir = 1'(dir);
      checks++;
      if (spawn_ready !== (j >= 0)) begin
         errors++;
         $display("FAIL spawn_ready: got %b expected %b",
                  spawn_ready, (j >= 0));
      end
      @(negedge clk);
      spawn_valid = 1'b0;
      if (j >= 0) begin
         m_act[j] = 1; m_pend[j] = 0; m_size[j] = sz > 3 ? 3 : sz;
         m_x[j] = x; m_y[j] = y; m_dir[j] = dir; m_vy[j] = 0;
      end
   endtask

   task automatic model_hit(input int s);
      if (m_act[s] != 0 && m_pend[s] == 0) m_pend[s] = 1;
   endtask

   task automatic hit(input int s);
      @(negedge clk);
      hit_valid = 1'b1; hit_slot = 3'(s);
      @(negedge clk);
      hit_valid = 1'b0;
      model_hit(s);
   endtask

   task automatic frame(input string tag);
      int es, ec, ns, nc;
      model_frame(es, ec);
      @(negedge clk);
      sof = 1'b1;
      @(negedge clk);
      sof = 1'b0;
      ns = 0; nc = 0;
      repeat (20) begin
         ns += int'(split);
         nc += int'(allCleared);
         @(negedge clk);
      end
      checks++;
      if (ns != es || nc != ec || activeCount !== 4'(m_cnt)) begin
         errors++;
         $display("FAIL %s pulses: split %0d/%0d clr %0d/%0d cnt %0d/%0d",
                  tag, ns, es, nc, ec, activeCount, m_cnt);
      end
      check_state(tag);
   endtask

   task automatic query(input int px, input int py, input string tag);
      logic [28:0] o, e;
      int d;
      e = '0;
      for (int i = NS - 1; i >= 0; i--) begin
         d = 8 << m_size[i];
         if (m_act[i] != 0 && px >= m_x[i] && px < m_x[i] + d &&
             py >= m_y[i] && py < m_y[i] + d)
            e = {1'b1, 3'(i), 3'(m_size[i]), 11'(px - m_x[i]),
                 11'(py - m_y[i])};
      end
      @(negedge clk);
      pixelX = 11'(px); pixelY = 11'(py);
      @(negedge clk);
      o = {drawingRequest, drawSlot, drawSize, offsetX, offsetY};
      checks++;
      if (o !== e) begin
         errors++;
         $display("FAIL %s query(%0d,%0d): got %h expected %h",
                  tag, px, py, o, e);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset = 1'b1;
      do_reset();
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if ({spawn_ready, drawingRequest, drawSlot, drawSize, offsetX,
           offsetY, activeCount, split, allCleared} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got nonzero expected 0");
      end
      reset = 1'b0;
      #1;
      checks++;
      if (spawn_ready !== 1'b1) begin
         errors++;
         $display("FAIL ready_after_reset: got %b expected 1", spawn_ready);
      end
      check_state("reset");
   endtask

   task automatic test_spawn_move();
      do_reset();
      spawn(2, 100, 100, 1);
      check_state("spawn");
      frame("move");
      checks++;
      if ({dut.slots[0].x, dut.slots[0].y, dut.slots[0].vy,
           activeCount} !== {11'd102, 11'd101, 8'sd1, 4'd1}) begin
         errors++;
         $display("FAIL move_const: got x%0d y%0d vy%0d cnt%0d expected 102 101 1 1",
                  dut.slots[0].x, dut.slots[0].y, dut.slots[0].vy,
                  activeCount);
      end
   endtask

   task automatic test_wall();
      do_reset();
      spawn(2, 607, 100, 1);
      frame("wall");
      checks++;
      if ({dut.slots[0].x, dut.slots[0].dir} !== {11'd608, 1'b0}) begin
         errors++;
         $display("FAIL wall_const: got x%0d dir%0d expected 608 0",
                  dut.slots[0].x, dut.slots[0].dir);
      end
      do_reset();
      spawn(0, 1, 50, 0);
      frame("left_wall");
   endtask

   task automatic test_floor();
      bit seen;
      seen = 0;
      do_reset();
      spawn(2, 100, 380, 0);
      for (int f = 0; f < 10 && !seen; f++) begin
         frame("floor");
         if (m_y[0] == 408 && m_vy[0] == -20) begin
            seen = 1;
            checks++;
            if ({dut.slots[0].y, dut.slots[0].vy} !==
                {11'd408, -8'sd20}) begin
               errors++;
               $display("FAIL floor_const: got y%0d vy%0d expected 408 -20",
                        dut.slots[0].y, dut.slots[0].vy);
            end
         end
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL floor_reach: got no bounce expected bounce");
      end
   endtask

   task automatic test_split_pop();
      do_reset();
      spawn(1, 200, 100, 1);
      hit(0);
      frame("split");
      checks++;
      if ({dut.slots[0].size, dut.slots[0].dir, dut.slots[0].vy,
           dut.slots[1].active, dut.slots[1].size, dut.slots[1].dir,
           dut.slots[1].vy} !==
          {3'd0, 1'b0, -8'sd16, 1'b1, 3'd0, 1'b1, -8'sd16}) begin
         errors++;
         $display("FAIL split_const: got children wrong expected s0 d0/d1 vy-16");
      end
      hit(0);
      hit(1);
      frame("pop");
   endtask

   task automatic test_full();
      do_reset();
      spawn(3, 100, 50, 1);
      spawn(0, 500, 40, 0);
      spawn(1, 300, 200, 1);
      spawn(0, 450, 40, 1);
      spawn(0, 400, 40, 0);
      spawn(1, 300, 200, 1);
      spawn(0, 550, 40, 1);
      spawn(0, 580, 40, 0);
      spawn(0, 10, 10, 0);
      hit(0);
      frame("full_split");
      checks++;
      if (activeCount !== 4'd8) begin
         errors++;
         $display("FAIL full_count: got %0d expected 8", activeCount);
      end
      query(m_x[2] + 3, m_y[2] + 4, "overlap");
      checks++;
      if (drawSlot !== 3'd2) begin
         errors++;
         $display("FAIL overlap_slot: got %0d expected 2", drawSlot);
      end
      query(5, 5, "empty");
   endtask

   task automatic test_spawn_hit();
      do_reset();
      spawn(2, 50, 60, 1);
      @(negedge clk);
      spawn_valid = 1'b1; spawn_size = 3'd1;
      spawn_x = 11'd400; spawn_y = 11'd90; spawn_dir = 1'b0;
      hit_valid = 1'b1; hit_slot = 3'd0;
      checks++;
      if (spawn_ready !== 1'b1) begin
         errors++;
         $display("FAIL spawn_hit_ready: got %b expected 1", spawn_ready);
      end
      @(negedge clk);
      spawn_valid = 1'b0; hit_valid = 1'b0;
      m_act[1] = 1; m_pend[1] = 0; m_size[1] = 1; m_x[1] = 400;
      m_y[1] = 90; m_dir[1] = 0; m_vy[1] = 0;
      model_hit(0);
      check_state("spawn_hit");
      frame("spawn_hit_frame");
   endtask

   task automatic test_reset_mid_pass();
      do_reset();
      spawn(2, 100, 100, 1);
      spawn(1, 300, 100, 0);
      hit(1);
      @(negedge clk);
      sof = 1'b1;
      @(negedge clk);
      sof = 1'b0;
      repeat (2) @(negedge clk);
      do_reset();
      check_state("mid_reset");
      checks++;
      if ({activeCount, split, allCleared} !== '0) begin
         errors++;
         $display("FAIL mid_reset_out: got nonzero expected 0");
      end
      spawn(0, 20, 20, 1);
      frame("after_mid_reset");
   endtask

   task automatic test_random();
      int op, s, d;
      do_reset();
      for (int it = 0; it < 60; it++) begin
         op = $urandom_range(0, 9);
         if (op < 4) begin
            spawn($urandom_range(0, 7), $urandom_range(1, 600),
                  $urandom_range(0, 370), $urandom_range(0, 1));
         end else if (op < 7) begin
            hit($urandom_range(0, NS - 1));
         end else begin
            frame("rand");
            s = $urandom_range(0, NS - 1);
            if (m_act[s] != 0) begin
               d = 8 << m_size[s];
               query(m_x[s] + $urandom_range(0, d - 1),
                     m_y[s] + $urandom_range(0, d - 1), "rand_in");
            end
            query($urandom_range(0, 639), $urandom_range(0, 479),
                  "rand_any");
         end
      end
      frame("rand_final");
   endtask

   initial begin
      test_reset();
      test_spawn_move();
      test_wall();
      test_floor();
      test_split_pop();
      test_full();
      test_spawn_hit();
      test_reset_mid_pass();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/bubble_pool.md
# bubble_pool

Parametrised multi-bubble manager and successor to the single-bubble object. It owns NUM_SLOTS bubble slots and runs per-frame physics for each: horizontal drift, gravity, wall and floor bounce. It splits a hit bubble into two smaller children, or pops it at minimum size. It answers per-pixel "which bubble covers this pixel" queries for the VGA mux, and sits between game control (spawn/hit) and the external ball bitmap ROM.

## Interface
- NUM_SLOTS, 8: number of bubble slots (2..16).
- MAX_SIZE, 3: largest size code. Diameter = BASE_DIAM << size.
- BASE_DIAM, 8: diameter in pixels of a size-0 bubble.
- SCREEN_W, 640 / FLOOR_Y, 440: right wall x and floor y (pixels).
- X_SPEED, 2: horizontal pixels per frame.
- GRAVITY, 1: vy increment per frame.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- startOfFrame  in  1  one-cycle pulse per frame; starts the update pass.
- spawn_valid / spawn_ready  in/out  1  spawn handshake; a transfer occurs when both are high on a clk edge.
- spawn_size  in  3  size code; values above MAX_SIZE are clamped to MAX_SIZE.
- spawn_x, spawn_y  in  11  top-left position of the new bubble.
- spawn_dir  in  1  1 = moving right.
- hit_valid  in  1  one-cycle hit report.
- hit_slot  in  $clog2(NUM_SLOTS)  slot that was hit.
- pixelX, pixelY  in  11  current VGA pixel.
- drawingRequest  out  1  pixel is inside a bubble bounding square (registered).
- drawSlot  out  $clog2(NUM_SLOTS)  covering slot; lowest index wins.
- drawSize  out  3  size of the covering slot.
- offsetX, offsetY  out  11  pixel offset from the covering slot's top-left.
- activeCount  out  $clog2(NUM_SLOTS)+1  number of live slots.
- split  out  1  one-cycle pulse per processed hit.
- allCleared  out  1  one-cycle pulse when activeCount becomes 0 at the end of a pass.

## Operation
- Per-slot state: active, pending, size, x, y (11 b unsigned), dir, vy (8 b signed, saturating at ±127).
- FSM states:
  - IDLE: on startOfFrame go to UPDATE with idx = 0.
  - UPDATE: processes slot idx in one cycle.
    - Inactive slot: skip.
    - pending set and size > 0: go to SPLIT.
    - pending set and size = 0: clear active (pop).
    - Otherwise apply motion.
    - After idx = NUM_SLOTS-1, go to DONE.
  - SPLIT: one cycle.
    - Slot idx becomes size-1, dir = 0, vy = -16, pending cleared.
    - The lowest free slot receives size-1, dir = 1, vy = -16, at the same x, y.
    - If no slot is free, only the left child exists.
    - Return to UPDATE at idx+1. The new child is not moved in this pass.
  - DONE: update activeCount, pulse allCleared if applicable, return to IDLE.
- Motion for one slot:
  - x += ±X_SPEED. On reaching x ≤ 0 or x + diam ≥ SCREEN_W, clamp x to the wall and flip dir.
  - vy += GRAVITY, then y += vy.
  - If y + diam ≥ FLOOR_Y: y = FLOOR_Y - diam and vy = -(12 + 4·size).
- Spawn:
  - spawn_ready = 1 only in IDLE with at least one free slot.
  - The accepted bubble takes the lowest free slot with vy = 0 and pending = 0.
- Hit:
  - A hit sets pending[hit_slot] only if the slot is active and pending is clear.
  - Hits on the slot being processed in the current UPDATE/SPLIT cycle are dropped.
- Pixel query:
  - A parallel bounding-box compare over all active slots; the lowest index wins.
  - Result registered, giving 1 cycle of latency.
  - No match: drawingRequest = 0 and all other draw outputs = 0.

## Timing
- Reset values: all slots inactive and zeroed. FSM = IDLE, every output 0. spawn_ready rises on the first cycle after reset deasserts.
- A pass takes between NUM_SLOTS+1 and 2·NUM_SLOTS+1 cycles. startOfFrame is ignored outside IDLE.
- split pulses in the SPLIT cycle, and also in the pop cycle of a size-0 bubble.
- Reset asserted mid-pass aborts the pass immediately. No partial state survives.
- Simultaneous spawn and hit: both are accepted. The spawned slot is never the hit target in the same cycle.

## Configuration
- BUBBLE_POOL_FREEZE_EN defined:
  - Adds input port freeze (1 b).
  - While freeze is high, UPDATE skips motion but still processes splits and pops. Children keep vy = -16, which is applied on the first unfrozen frame.
- Not defined: the port is absent and motion always runs.

## Structure
- The shared package bubble_pkg holds:
  - the slot-state struct typedef;
  - the FSM enum;
  - the bounce-velocity function;
  - the diameter function (BASE_DIAM << size).
- One sub-module, bubble_hit_test: a combinational priority bounding-box search over the slot array that produces slot, size and offsets. bubble_pool registers its outputs.

## Test plan
- Reset then spawn (size 2, x 100, y 100, dir 1) -> slot 0 active, activeCount 1. After one frame: x = 102, y = 101, vy = 1.
- Bubble at x = SCREEN_W - 32 - 1, size 2, dir 1; one frame -> x = 608, dir = 0.
- Size-2 bubble falls to the floor -> y = 408, vy = -20 on the bounce frame.
- Hit slot 0 (size 1) with 7 free slots; next frame -> slot 0 size 0 dir 0, slot 1 size 0 dir 1, both vy = -16, one split pulse, activeCount 2.
- Hit both size-0 bubbles -> both popped, activeCount 0, allCleared pulses once at DONE.
- Fill all 8 slots: spawn_ready = 0. Hit a size-3 bubble -> only one child exists, activeCount stays 8. Pixel inside slots 2 and 5 overlap -> drawSlot = 2 one cycle later.
